// File: rtl/seq_cmp_mul_if.sv
// rtl/seq_cmp_mul_if.sv - operand/handshake/result bundle for seq_cmp_mul
interface seq_cmp_mul_if #(
    parameter int W = 4
);
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           PB0;
    logic           start;
    logic           busy;
    logic           done;
    logic [2*W-1:0] out;

    modport master (
        output a, b, PB0, start,
        input  busy, done, out
    );

    modport slave (
        input  a, b, PB0, start,
        output busy, done, out
    );
endinterface

// File: rtl/seq_cmp_mul.sv
// rtl/seq_cmp_mul.sv - W-bit magnitude compare / shift-add multiply, start/busy/done handshake
// Optional PB0 synchroniser + debounce enabled by defining CMP_MUL_DEBOUNCE_EN.
module seq_cmp_mul #(
    parameter int W          = 4,
    parameter int DEB_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_cmp_mul_if.slave bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    if (W < 1 || W > 16 || DEB_CYCLES < 1) begin : g_param_check
        $error("seq_cmp_mul: illegal W or DEB_CYCLES");
    end

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t         state_q;
    logic [W-1:0]   mcand_q;
    logic [W-1:0]   mplier_q;
    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] out_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic           done_q;

    logic           mode_d;
    logic [2*W-1:0] partial_d;
    logic [2*W-1:0] acc_d;
    logic [2*W+2:0] cmp_ext_d;
    logic [2*W-1:0] cmp_d;

`ifdef CMP_MUL_DEBOUNCE_EN
    localparam int DCW = $clog2(DEB_CYCLES + 1);

    logic [1:0]     sync_q;
    logic [DCW-1:0] deb_cnt_q;
    logic           mode_deb_q;

    // Mode flips only after the synchronised button disagrees for DEB_CYCLES clocks in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 2'b00;
            deb_cnt_q  <= '0;
            mode_deb_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], bus.PB0};
            if (sync_q[1] != mode_deb_q) begin
                if (deb_cnt_q == DCW'(DEB_CYCLES - 1)) begin
                    mode_deb_q <= sync_q[1];
                    deb_cnt_q  <= '0;
                end else begin
                    deb_cnt_q <= deb_cnt_q + DCW'(1);
                end
            end else begin
                deb_cnt_q <= '0;
            end
        end
    end

    assign mode_d = mode_deb_q;
`else
    assign mode_d = bus.PB0;
`endif

    // Compare result is built wider than out so the 3-bit code still elaborates for W=1.
    always_comb begin
        partial_d = {{W{1'b0}}, mplier_q} << cnt_q;
        acc_d     = acc_q + (mcand_q[cnt_q] ? partial_d : '0);
        cmp_ext_d = {{(2*W){1'b0}}, (bus.a > bus.b), (bus.a == bus.b), (bus.a < bus.b)};
        cmp_d     = cmp_ext_d[2*W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        mcand_q  <= bus.a;
                        mplier_q <= bus.b;
                        if (mode_d) begin
                            state_q <= S_MUL;
                            busy_q  <= 1'b1;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                        end else begin
                            out_q  <= cmp_d;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        out_q   <= acc_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.out  = out_q;
endmodule

// File: tb/tb_seq_cmp_mul.sv
// tb/tb_seq_cmp_mul.sv - directed and randomized checks of seq_cmp_mul against an arithmetic model
module tb_seq_cmp_mul;
    localparam int W        = 4;
    localparam int DEB_WAIT = 24;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_cmp_mul_if #(.W(W)) bus ();
    seq_cmp_mul_if #(.W(2)) bus2 ();

    seq_cmp_mul #(.W(W), .DEB_CYCLES(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    seq_cmp_mul #(.W(2), .DEB_CYCLES(16)) dut2 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus2)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit mode_model = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input int av, input int bv, input bit mode);
        if (mode) return 32'(av * bv);
        return (av > bv ? 32'd4 : 32'd0) + (av == bv ? 32'd2 : 32'd0) + (av < bv ? 32'd1 : 32'd0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input bit m);
        bus.PB0 = m;
`ifdef CMP_MUL_DEBOUNCE_EN
        if (m != mode_model) repeat (DEB_WAIT) tick();
`endif
        mode_model = m;
    endtask

    task automatic run_op(input int av, input int bv, input bit mode, input bit scramble);
        logic [31:0] exp;
        exp = model(av, bv, mode);
        set_mode(mode);
        bus.a = W'(av);
        bus.b = W'(bv);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        if (scramble) begin
            bus.a = W'($urandom);
            bus.b = W'($urandom);
        end
        if (!mode) begin
            chk("cmp_done", 32'(bus.done), 1);
            chk("cmp_busy", 32'(bus.busy), 0);
            chk("cmp_out", 32'(bus.out), exp);
        end else begin
            chk("mul_busy_k", 32'(bus.busy), 1);
            chk("mul_done_k", 32'(bus.done), 0);
            repeat (W - 1) begin
                tick();
                chk("mul_busy", 32'(bus.busy), 1);
                chk("mul_done_early", 32'(bus.done), 0);
            end
            tick();
            chk("mul_done", 32'(bus.done), 1);
            chk("mul_busy_end", 32'(bus.busy), 0);
            chk("mul_out", 32'(bus.out), exp);
        end
        tick();
        chk("done_pulse", 32'(bus.done), 0);
        chk("out_hold", 32'(bus.out), exp);
    endtask

    initial begin
        int dones;
        int ra, rb;
        bit rm;
        logic [31:0] exp;

        rst_n = 1'b0;
        bus.a = '0; bus.b = '0; bus.PB0 = 1'b0; bus.start = 1'b0;
        bus2.a = '0; bus2.b = '0; bus2.PB0 = 1'b0; bus2.start = 1'b0;
        repeat (3) tick();
        chk("rst_out", 32'(bus.out), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_out_w2", 32'(bus2.out), 0);
        rst_n = 1'b1;
        tick();

        run_op(5, 3, 1'b0, 1'b0);
        run_op(3, 3, 1'b0, 1'b0);
        run_op(1, 3, 1'b0, 1'b0);
        run_op(15, 15, 1'b1, 1'b1);
        run_op(0, 9, 1'b1, 1'b1);
        run_op(15, 0, 1'b1, 1'b0);

        // W=2 instance
        bus2.a = 2'd3; bus2.b = 2'd3; bus2.PB0 = 1'b1;
`ifdef CMP_MUL_DEBOUNCE_EN
        repeat (DEB_WAIT) tick();
`endif
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        chk("w2_busy_k", 32'(bus2.busy), 1);
        tick();
        chk("w2_busy", 32'(bus2.busy), 1);
        chk("w2_done_early", 32'(bus2.done), 0);
        tick();
        chk("w2_mul_done", 32'(bus2.done), 1);
        chk("w2_mul_out", 32'(bus2.out), 9);
        bus2.a = 2'd1; bus2.b = 2'd3; bus2.PB0 = 1'b0;
`ifdef CMP_MUL_DEBOUNCE_EN
        repeat (DEB_WAIT) tick();
`endif
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        chk("w2_cmp_done", 32'(bus2.done), 1);
        chk("w2_cmp_out", 32'(bus2.out), 1);

        // start while busy is ignored; operand changes mid-op are ignored
        set_mode(1'b1);
        bus.a = 4'd7; bus.b = 4'd6; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.a = 4'd2; bus.b = 4'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.a = 4'd9; bus.b = 4'd9;
        tick();
        chk("ign_done_early", 32'(bus.done), 0);
        tick();
        chk("ign_done", 32'(bus.done), 1);
        chk("ign_out", 32'(bus.out), 32'h2A);
        dones = 0;
        repeat (6) begin
            tick();
            dones += int'(bus.done);
        end
        chk("ign_no_second", 32'(dones), 0);
        chk("ign_out_hold", 32'(bus.out), 32'h2A);

        // reset mid-multiply
        bus.a = 4'd9; bus.b = 4'd9; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out", 32'(bus.out), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_done", 32'(bus.done), 0);
        mode_model = 1'b0;
        dones = 0;
        repeat (3) begin
            tick();
            dones += int'(bus.done);
        end
        chk("abort_no_done", 32'(dones), 0);
        rst_n = 1'b1;
        tick();
        run_op(3, 5, 1'b1, 1'b0);

        // start held high: compare accepted every edge
        set_mode(1'b0);
        bus.start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ra = int'($urandom_range(15));
            rb = int'($urandom_range(15));
            bus.a = W'(ra); bus.b = W'(rb);
            tick();
            chk("held_cmp_done", 32'(bus.done), 1);
            chk("held_cmp_out", 32'(bus.out), model(ra, rb, 1'b0));
        end
        bus.start = 1'b0;
        tick();

        // start held high: multiply re-accepted in the done cycle
        set_mode(1'b1);
        bus.a = 4'd3; bus.b = 4'd5; bus.start = 1'b1;
        tick();
        bus.a = 4'd2; bus.b = 4'd7;
        for (int c = 1; c <= 2 * W + 1; c++) begin
            tick();
            chk("held_mul_done", 32'(bus.done), ((c == W) || (c == 2 * W + 1)) ? 1 : 0);
            chk("held_mul_busy", 32'(bus.busy), ((c == W) || (c == 2 * W + 1)) ? 0 : 1);
            if (c == W) chk("held_mul_out1", 32'(bus.out), 15);
        end
        chk("held_mul_out2", 32'(bus.out), 14);
        bus.start = 1'b0;
        tick();

`ifdef CMP_MUL_DEBOUNCE_EN
        set_mode(1'b0);
        bus.PB0 = 1'b1;
        repeat (5) tick();
        bus.PB0 = 1'b0;
        repeat (20) tick();
        run_op(5, 3, 1'b0, 1'b0);
        run_op(3, 5, 1'b1, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            ra = int'($urandom_range(15));
            rb = int'($urandom_range(15));
            rm = 1'($urandom_range(1));
            run_op(ra, rb, rm, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
